// File: rtl/pipe_register_file.sv
// Scoreboarded register file: two combinational read ports, E/M write ports, per-register pending-write counters.
// Define RF_BYPASS_EN to forward same-cycle commits to the read ports and exempt satisfied sources from stall.
module pipe_register_file #(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 4,
    parameter int NREG     = 15,
    parameter int PEND_WID = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    output logic [DATA_WID-1:0] valA,
    output logic [DATA_WID-1:0] valB,
    input  logic                weE,
    input  logic [ADDR_WID-1:0] destE,
    input  logic [DATA_WID-1:0] valE,
    input  logic                weM,
    input  logic [ADDR_WID-1:0] destM,
    input  logic [DATA_WID-1:0] valM,
    input  logic                rsv_valid,
    input  logic [ADDR_WID-1:0] rsv_dst,
    output logic                stall,
    output logic                sb_err
);

    localparam int NSPEC = 2 ** ADDR_WID;
    localparam logic [ADDR_WID-1:0] NREG_A   = ADDR_WID'(NREG);
    localparam logic [PEND_WID-1:0] PEND_MAX = '1;

    // Arrays span the whole specifier space so any index is legal; entries >= NREG stay 0.
    logic [DATA_WID-1:0] regs     [NSPEC];
    logic [PEND_WID-1:0] pend     [NSPEC];
    logic [PEND_WID-1:0] pend_nxt [NSPEC];

    logic commit_e, commit_m, rsv_ok, ovf;
    logic sat_a, sat_b;
    int   tmp;

    assign commit_e = weE && (destE < NREG_A);
    assign commit_m = weM && (destM < NREG_A);
    assign rsv_ok   = rsv_valid && (rsv_dst < NREG_A);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NSPEC; i++) regs[i] <= '0;
        end else begin
            if (commit_e) regs[destE] <= valE;
            if (commit_m) regs[destM] <= valM;
        end
    end

    always_comb begin
        ovf = 1'b0;
        tmp = 0;
        for (int r = 0; r < NSPEC; r++) begin
            tmp = int'(pend[r]);
            if (rsv_ok && rsv_dst == ADDR_WID'(r)) tmp = tmp + 1;
            if (commit_e && destE == ADDR_WID'(r)) tmp = tmp - 1;
            if (commit_m && destM == ADDR_WID'(r)) tmp = tmp - 1;
            if (tmp < 0) tmp = 0;
            // Only a reserve with no offsetting commit can push past the maximum.
            if (tmp > int'(PEND_MAX)) begin
                ovf         = 1'b1;
                pend_nxt[r] = pend[r];
            end else begin
                pend_nxt[r] = PEND_WID'(tmp);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NSPEC; i++) pend[i] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NSPEC; i++) pend[i] <= pend_nxt[i];
            if (ovf) sb_err <= 1'b1;
        end
    end

    always_comb begin
        valA = '0;
        valB = '0;
        if (srcA < NREG_A) begin
            valA = regs[srcA];
`ifdef RF_BYPASS_EN
            if (commit_e && destE == srcA) valA = valE;
            if (commit_m && destM == srcA) valA = valM;
`endif
        end
        if (srcB < NREG_A) begin
            valB = regs[srcB];
`ifdef RF_BYPASS_EN
            if (commit_e && destE == srcB) valB = valE;
            if (commit_m && destM == srcB) valB = valM;
`endif
        end
    end

    always_comb begin
        stall = 1'b0;
        sat_a = 1'b0;
        sat_b = 1'b0;
`ifdef RF_BYPASS_EN
        sat_a = (pend[srcA] == PEND_WID'(1)) &&
                ((commit_e && destE == srcA) || (commit_m && destM == srcA));
        sat_b = (pend[srcB] == PEND_WID'(1)) &&
                ((commit_e && destE == srcB) || (commit_m && destM == srcB));
`endif
        if (srcA < NREG_A && pend[srcA] != '0 && !sat_a) stall = 1'b1;
        if (srcB < NREG_A && pend[srcB] != '0 && !sat_b) stall = 1'b1;
    end

endmodule

// File: tb/tb_pipe_register_file.sv
// Directed bench for pipe_register_file; expectations follow RF_BYPASS_EN when it is defined.
module tb_pipe_register_file;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  srcA, srcB, destE, destM, rsv_dst;
    logic [31:0] valA, valB, valE, valM;
    logic        weE, weM, rsv_valid, stall, sb_err;

    int checks = 0;
    int fails  = 0;

    pipe_register_file dut (
        .CLK(CLK), .RST_N(RST_N),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .weE(weE), .destE(destE), .valE(valE),
        .weM(weM), .destM(destM), .valM(valM),
        .rsv_valid(rsv_valid), .rsv_dst(rsv_dst),
        .stall(stall), .sb_err(sb_err)
    );

    always #5 CLK = ~CLK;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic idle();
        weE = 0; weM = 0; rsv_valid = 0;
        destE = 0; destM = 0; valE = 0; valM = 0; rsv_dst = 0;
        srcA = 4'hF; srcB = 4'hF;
    endtask

    // Advance past one rising edge, then clear all stimulus.
    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic test_reset();
        RST_N = 0;
        idle();
        srcA = 0; srcB = 14;
        #3;
        checks++; if (valA !== 32'h0) begin fails++; $display("FAIL reset_valA got %h exp 0", valA); end
        checks++; if (valB !== 32'h0) begin fails++; $display("FAIL reset_valB got %h exp 0", valB); end
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (sb_err !== 1'b0) begin fails++; $display("FAIL reset_sb_err got %b exp 0", sb_err); end
        @(negedge CLK);
        RST_N = 1;
        tick();
    endtask

    task automatic test_writes();
        weE = 1; destE = 3; valE = 32'h11;
        weM = 1; destM = 5; valM = 32'h22;
        tick();
        weE = 1; destE = 4'hF; valE = 32'hDEAD;
        tick();
        srcA = 3; srcB = 5;
        #1;
        checks++; if (valA !== 32'h11) begin fails++; $display("FAIL wr_r3 got %h exp 11", valA); end
        checks++; if (valB !== 32'h22) begin fails++; $display("FAIL wr_r5 got %h exp 22", valB); end
        srcA = 4'hF; srcB = 0;
        #1;
        checks++; if (valA !== 32'h0) begin fails++; $display("FAIL rnone_read got %h exp 0", valA); end
        checks++; if (valB !== 32'h0) begin fails++; $display("FAIL r0_untouched got %h exp 0", valB); end
    endtask

    task automatic test_conflict();
        weE = 1; destE = 2; valE = 32'hAA;
        weM = 1; destM = 2; valM = 32'hBB;
        tick();
        srcB = 2;
        #1;
        checks++; if (valB !== 32'hBB) begin fails++; $display("FAIL conflict_m_wins got %h exp bb", valB); end
    endtask

    task automatic test_bypass();
        weM = 1; destM = 4; valM = 32'h1;
        tick();
        weE = 1; destE = 4; valE = 32'h9; srcA = 4;
        #1;
        checks++;
        if (valA !== (BYP ? 32'h9 : 32'h1)) begin
            fails++; $display("FAIL bypass_same_cycle got %h exp %h", valA, BYP ? 32'h9 : 32'h1);
        end
        tick();
        srcA = 4;
        #1;
        checks++; if (valA !== 32'h9) begin fails++; $display("FAIL bypass_next_cycle got %h exp 9", valA); end
    endtask

    task automatic test_scoreboard();
        rsv_valid = 1; rsv_dst = 6;
        tick();
        srcA = 6;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL sb_pending got %b exp 1", stall); end
        weM = 1; destM = 6; valM = 32'h66;
        #1;
        checks++;
        if (stall !== !BYP) begin fails++; $display("FAIL sb_commit_cycle got %b exp %b", stall, !BYP); end
        tick();
        srcA = 6;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_cleared got %b exp 0", stall); end
        // srcB path, reserve+commit net-out, and dual decrement
        rsv_valid = 1; rsv_dst = 9;
        tick();
        rsv_valid = 1; rsv_dst = 9; weE = 1; destE = 9; valE = 32'h99;
        tick();
        srcB = 9;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL sb_net_out got %b exp 1", stall); end
        weE = 1; destE = 9; valE = 32'h99;
        tick();
        rsv_valid = 1; rsv_dst = 10;
        tick();
        rsv_valid = 1; rsv_dst = 10;
        tick();
        weE = 1; destE = 10; weM = 1; destM = 10;
        tick();
        srcA = 10; srcB = 9;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_dual_dec got %b exp 0", stall); end
        // reserve to RNONE ignored
        rsv_valid = 1; rsv_dst = 4'hF;
        tick();
        srcA = 4'hF;
        #1;
        checks++; if (stall !== 1'b0 || sb_err !== 1'b0) begin
            fails++; $display("FAIL sb_rnone got stall=%b err=%b exp 0 0", stall, sb_err);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            rsv_valid = 1; rsv_dst = 1;
            tick();
        end
        checks++; if (sb_err !== 1'b0) begin fails++; $display("FAIL ovf_three_ok got %b exp 0", sb_err); end
        rsv_valid = 1; rsv_dst = 1;
        tick();
        checks++; if (sb_err !== 1'b1) begin fails++; $display("FAIL ovf_fourth got %b exp 1", sb_err); end
        for (int i = 0; i < 2; i++) begin
            weE = 1; destE = 1; valE = 32'h1;
            tick();
        end
        srcA = 1;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL ovf_pend_held got %b exp 1", stall); end
        weE = 1; destE = 1;
        tick();
        weM = 1; destM = 1;
        tick();
        srcA = 1;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL ovf_drained got %b exp 0", stall); end
        checks++; if (sb_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", sb_err); end
    endtask

    task automatic test_reset_mid();
        rsv_valid = 1; rsv_dst = 7;
        tick();
        rsv_valid = 1; rsv_dst = 7;
        tick();
        weE = 1; destE = 7; valE = 32'h5;
        tick();
        srcA = 7;
        #1;
        checks++; if (valA !== 32'h5 || stall !== 1'b1) begin
            fails++; $display("FAIL mid_pre got val=%h stall=%b exp 5 1", valA, stall);
        end
        #1 RST_N = 0;
        #1;
        checks++; if (valA !== 32'h0) begin fails++; $display("FAIL mid_r7 got %h exp 0", valA); end
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL mid_stall got %b exp 0", stall); end
        checks++; if (sb_err !== 1'b0) begin fails++; $display("FAIL mid_sb_err got %b exp 0", sb_err); end
        @(negedge CLK);
        RST_N = 1;
        weE = 1; destE = 7; valE = 32'h77;
        tick();
        srcA = 7;
        #1;
        checks++; if (valA !== 32'h77 || stall !== 1'b0) begin
            fails++; $display("FAIL post_reset_wr got val=%h stall=%b exp 77 0", valA, stall);
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_conflict();
        test_bypass();
        test_scoreboard();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
